// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Purpose:
//   Shares one physical-memory port between an instruction cache (read-only
//   line fills) and a data cache (line fills and writebacks). A three-state
//   FSM (IDLE, SERVE_I, SERVE_D) grants one requester at a time and holds
//   that grant until physical memory returns pmem_resp. Ties in IDLE are
//   broken round-robin using a last_grant register, so two requesters that
//   are both held continuously are served alternately.
//
// Parameters:
//   s_line  cacheline width in bits
//   s_addr  physical address width in bits
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_pmem_read               instruction-cache fill request
//   i_pmem_address            instruction-cache line address
//   i_pmem_rdata, i_pmem_resp line data / completion to the instruction cache
//   d_pmem_read, d_pmem_write data-cache fill / writeback requests
//   d_pmem_address            data-cache line address
//   d_pmem_wdata              data-cache writeback line
//   d_pmem_rdata, d_pmem_resp line data / completion to the data cache
//   pmem_read, pmem_write     commands to physical memory
//   pmem_address, pmem_wdata  address / write line to physical memory
//   pmem_rdata, pmem_resp     read line / completion from physical memory
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,

  // Instruction-cache side
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  // Data-cache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  // Physical-memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;

  logic i_req;
  logic d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // ---------------------------------------------------------------------------
  // State registers. last_grant resets to D so the first tie after reset goes
  // to the instruction cache.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Requests are only sampled in IDLE; once a grant is made
  // it is held until pmem_resp regardless of what the requester does, because
  // physical memory has no way to abort an access already in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Tie: serve whoever was not served last.
          if (last_grant_q == GRANT_D) begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
          end else begin
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
          end
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end
      end

      SERVE_I, SERVE_D: begin
        // No timeout: memory latency is unbounded.
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output steering. Commands and responses are decoded purely from state_q,
  // so the asynchronous reset removes them immediately without waiting for a
  // clock edge. pmem_resp is forwarded combinationally to the owner only.
  // ---------------------------------------------------------------------------
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = i_pmem_address;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    case (state_q)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end

      SERVE_D: begin
        // A writeback takes priority if the data cache raises both.
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        d_pmem_resp  = pmem_resp;
      end

      default: begin
        // IDLE: no command issued and pmem_resp is ignored.
      end
    endcase
  end

  // Data paths are not gated: only the resp strobes tell a cache the data is
  // meant for it, so the line buses are shared wires.
  assign pmem_wdata   = d_pmem_wdata;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  localparam int LINE = 256;
  localparam int ADDR = 32;

  logic            clk;
  logic            rst;
  logic            i_pmem_read;
  logic [ADDR-1:0] i_pmem_address;
  logic [LINE-1:0] i_pmem_rdata;
  logic            i_pmem_resp;
  logic            d_pmem_read;
  logic            d_pmem_write;
  logic [ADDR-1:0] d_pmem_address;
  logic [LINE-1:0] d_pmem_wdata;
  logic [LINE-1:0] d_pmem_rdata;
  logic            d_pmem_resp;
  logic            pmem_read;
  logic            pmem_write;
  logic [ADDR-1:0] pmem_address;
  logic [LINE-1:0] pmem_wdata;
  logic [LINE-1:0] pmem_rdata;
  logic            pmem_resp;

  pmem_arbiter #(.s_line(LINE), .s_addr(ADDR)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected completion: which cache owns it and what memory should see.
  typedef struct {
    bit              is_d;
    bit              wr;
    logic [ADDR-1:0] addr;
    logic [LINE-1:0] wdata;
    logic [LINE-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input bit is_d, input bit wr, input logic [ADDR-1:0] a,
                            input logic [LINE-1:0] w, input logic [LINE-1:0] r);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = w;
    e.rdata = r;
    sb.push_back(e);
  endtask

  // Step to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait for a memory command; it must appear one cycle after the request
  // becomes visible in IDLE.
  task automatic wait_cmd(input string name);
    int waited;
    waited = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (pmem_read || pmem_write) begin
        waited = k;
        break;
      end
    end
    check({name, "_cmd_latency"}, LINE'(waited), LINE'(1));
  endtask

  task automatic respond(input int lat, input logic [LINE-1:0] rd);
    repeat (lat) cycle();
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pmem_read",   LINE'(pmem_read),   LINE'(0));
    check("rst_pmem_write",  LINE'(pmem_write),  LINE'(0));
    check("rst_i_pmem_resp", LINE'(i_pmem_resp), LINE'(0));
    check("rst_d_pmem_resp", LINE'(d_pmem_resp), LINE'(0));
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Monitor: every completion strobe pops one expected transaction.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (i_pmem_resp || d_pmem_resp)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none",
                 i_pmem_resp, d_pmem_resp);
      end else begin
        mon_e = sb.pop_front();
        check("mon_i_resp",     LINE'(i_pmem_resp),  LINE'(!mon_e.is_d));
        check("mon_d_resp",     LINE'(d_pmem_resp),  LINE'(mon_e.is_d));
        check("mon_pmem_write", LINE'(pmem_write),   LINE'(mon_e.wr));
        check("mon_pmem_read",  LINE'(pmem_read),    LINE'(!mon_e.wr));
        check("mon_address",    LINE'(pmem_address), LINE'(mon_e.addr));
        if (mon_e.wr) check("mon_wdata", pmem_wdata, mon_e.wdata);
        if (mon_e.is_d) check("mon_d_rdata", d_pmem_rdata, mon_e.rdata);
        else            check("mon_i_rdata", i_pmem_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LINE-1:0] r_ab, r1, r2, r3, r4, r5, r6, w1, w2, w3, rc;
    logic [31:0]     word;

    r_ab = {32{8'hAB}};
    r1   = {8{32'h1111_0001}};
    r2   = {8{32'h2222_0002}};
    r3   = {8{32'h3333_0003}};
    r4   = {8{32'h4444_0004}};
    r5   = {8{32'h5555_0005}};
    r6   = {8{32'h6666_0006}};
    w1   = {8{32'hDEAD_BEEF}};
    w2   = {8{32'hCAFE_F00D}};
    w3   = {8{32'h0BAD_0BAD}};

    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset: all commands/resps low.
    do_reset();

    // Single I fill at 0x60.
    i_pmem_address = 32'h0000_0060;
    i_pmem_read    = 1'b1;
    check("a_idle_no_cmd", LINE'(pmem_read), LINE'(0));
    expect_txn(1'b0, 1'b0, 32'h60, '0, r_ab);
    wait_cmd("a");
    check("a_pmem_read", LINE'(pmem_read),    LINE'(1));
    check("a_pmem_addr", LINE'(pmem_address), LINE'(32'h60));
    respond(0, r_ab);
    i_pmem_read = 1'b0;

    // Tie right after reset: I first, then D writeback.
    do_reset();
    i_pmem_address = 32'h0000_0100; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0200; d_pmem_wdata = w1; d_pmem_write = 1'b1;
    expect_txn(1'b0, 1'b0, 32'h100, '0, r1);
    expect_txn(1'b1, 1'b1, 32'h200, w1, r2);
    wait_cmd("b_i");
    respond(0, r1);
    i_pmem_read = 1'b0;
    wait_cmd("b_d");
    respond(2, r2);
    d_pmem_write = 1'b0;

    // Both held for four transactions: I, D, I, D (last grant was D).
    i_pmem_address = 32'h0000_0300; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0400; d_pmem_read = 1'b1;
    for (int t = 0; t < 4; t++) begin
      word = 32'hC0DE_0000 + 32'(t);
      rc   = {8{word}};
      expect_txn(t[0], 1'b0, t[0] ? 32'h400 : 32'h300, '0, rc);
      wait_cmd("c");
      respond(t, rc);
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;

    // D read and write together: write wins.
    d_pmem_address = 32'h0000_0500; d_pmem_wdata = w2;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    expect_txn(1'b1, 1'b1, 32'h500, w2, r3);
    wait_cmd("d");
    check("d_write_wins", LINE'(pmem_write), LINE'(1));
    check("d_read_off",   LINE'(pmem_read),  LINE'(0));
    respond(1, r3);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;

    // Asynchronous reset in the middle of SERVE_D; resp during reset ignored.
    d_pmem_address = 32'h0000_0600; d_pmem_wdata = w3; d_pmem_write = 1'b1;
    wait_cmd("e");
    check("e_write_before_rst", LINE'(pmem_write), LINE'(1));
    #2;
    rst = 1'b1; pmem_rdata = r4; pmem_resp = 1'b1;
    #1;
    check("e_write_async_drop", LINE'(pmem_write),  LINE'(0));
    check("e_read_async_drop",  LINE'(pmem_read),   LINE'(0));
    check("e_d_resp_in_rst",    LINE'(d_pmem_resp), LINE'(0));
    check("e_i_resp_in_rst",    LINE'(i_pmem_resp), LINE'(0));
    cycle();
    rst = 1'b0; pmem_resp = 1'b0; d_pmem_write = 1'b0;
    cycle();
    check("e_idle_write", LINE'(pmem_write), LINE'(0));
    check("e_idle_read",  LINE'(pmem_read),  LINE'(0));

    // First tie after reset goes to I; slow memory (20 cycles) while D waits.
    i_pmem_address = 32'h0000_0700; i_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0800; d_pmem_read = 1'b1;
    expect_txn(1'b0, 1'b0, 32'h700, '0, r5);
    wait_cmd("f_i");
    for (int k = 0; k < 20; k++) begin
      check("f_hold_addr",   LINE'(pmem_address), LINE'(32'h700));
      check("f_hold_d_resp", LINE'(d_pmem_resp),  LINE'(0));
      check("f_hold_read",   LINE'(pmem_read),    LINE'(1));
      cycle();
    end
    respond(0, r5);
    i_pmem_read = 1'b0;
    expect_txn(1'b1, 1'b0, 32'h800, '0, r6);
    wait_cmd("f_d");
    respond(0, r6);
    d_pmem_read = 1'b0;

    repeat (3) cycle();
    check("scoreboard_drained", LINE'(sb.size()), LINE'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter s_line, default 256, cacheline width in bits.
REQ-002 SHALL have parameter s_addr, default 32, physical address width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_pmem_read  input  1  instruction-cache line-fill request.
REQ-006 SHALL have port i_pmem_address  input  s_addr  instruction-cache line address.
REQ-007 SHALL have port i_pmem_rdata  output  s_line  line data to instruction cache.
REQ-008 SHALL have port i_pmem_resp  output  1  completion to instruction cache.
REQ-009 SHALL have ports d_pmem_read and d_pmem_write  input  1 each  data-cache fill and writeback requests.
REQ-010 SHALL have port d_pmem_address  input  s_addr  data-cache line address.
REQ-011 SHALL have port d_pmem_wdata  input  s_line  data-cache writeback line.
REQ-012 SHALL have port d_pmem_rdata  output  s_line  line data to data cache.
REQ-013 SHALL have port d_pmem_resp  output  1  completion to data cache.
REQ-014 SHALL have ports pmem_read and pmem_write  output  1 each  physical memory commands.
REQ-015 SHALL have ports pmem_address (output, s_addr) and pmem_wdata (output, s_line) to physical memory.
REQ-016 SHALL have ports pmem_rdata (input, s_line) and pmem_resp (input, 1) from physical memory.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; state and last_grant are registers.
REQ-018 IDLE: i request only -> SERVE_I; d request (read or write) only -> SERVE_D; none -> stay IDLE.
REQ-019 IDLE with both requesting: grant the requester not in last_grant; last_grant updates to the granted requester on entering SERVE_*.
REQ-020 Arbitration latency: a request first visible in IDLE cycle N SHALL see pmem_read/pmem_write asserted in cycle N+1.
REQ-021 IDLE: pmem_read=0, pmem_write=0, i_pmem_resp=0, d_pmem_resp=0; pmem_resp in IDLE ignored.
REQ-022 SERVE_I: pmem_read=1, pmem_write=0, pmem_address=i_pmem_address (combinational passthrough).
REQ-023 SERVE_D: pmem_read=d_pmem_read & ~d_pmem_write, pmem_write=d_pmem_write, pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata; write wins if both asserted.
REQ-024 pmem_wdata SHALL be d_pmem_wdata in all states (no gating required).
REQ-025 i_pmem_rdata and d_pmem_rdata SHALL equal pmem_rdata in all states; only resp is steered.
REQ-026 i_pmem_resp = pmem_resp in SERVE_I only; d_pmem_resp = pmem_resp in SERVE_D only; same cycle, no registering.
REQ-027 On pmem_resp in SERVE_*, next state SHALL be IDLE; any request pending that next cycle is arbitrated normally.
REQ-028 Grant SHALL be held until pmem_resp even if the granted requester deasserts its request; no abort.
REQ-029 Non-granted requester SHALL wait without its resp asserting; no request is lost while held asserted.
REQ-030 Multi-cycle pmem_resp latency SHALL be unbounded; FSM waits indefinitely in SERVE_*.

Reset
REQ-031 rst assertion SHALL immediately force state=IDLE and last_grant=D, independent of clk, including mid-transaction.
REQ-032 During and after reset all command and resp outputs SHALL be 0; first tie after reset grants I.

Verification
REQ-033 Reset, then i_pmem_read=1, addr 0x0000_0060 -> cycle+1 pmem_read=1, pmem_address=0x60; pmem_resp with rdata 0xAB..AB -> i_pmem_resp=1 same cycle, rdata matches, d_pmem_resp=0.
REQ-034 i_pmem_read and d_pmem_write both asserted in IDLE after reset -> I served first; after its resp, D served with pmem_write=1, pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
REQ-035 Both requesters held continuously for 4 transactions -> grants alternate I,D,I,D; each resp only to its owner.
REQ-036 d_pmem_read=1 and d_pmem_write=1 together -> pmem_write=1, pmem_read=0.
REQ-037 rst pulsed mid-SERVE_D between clock edges -> pmem_write and d_pmem_resp drop to 0 before next edge; pmem_resp during reset ignored; state IDLE after release.
REQ-038 pmem_resp delayed 20 cycles in SERVE_I while d requests -> d_pmem_resp stays 0, pmem_address stays i address for all 20 cycles.
